// File: rtl/rm_lane_sequencer_pkg.sv
// Shared types for the per-lane runtime-monitor sequence checker.
package rm_lane_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_SEEK     = 2'd1,
        ST_TRACK    = 2'd2,
        ST_HIT      = 2'd3
    } rm_seq_state_e;

    // Index width that stays legal (>=1 bit) even for a single-entry range.
    function automatic int rm_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rm_lane_sequencer_timer.sv
// Per-step window timer: loads the step window, counts down to zero, flags the last allowed cycle.
module rm_lane_sequencer_timer #(
    parameter int WIN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIN_W-1:0] i_load_val,
    output logic             o_expire
);

    logic [WIN_W-1:0] r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    // A zero count means unbounded, so only a count of exactly one expires.
    assign o_expire = (r_count == WIN_W'(1));

endmodule

// File: rtl/rm_lane_sequencer.sv
// Per-lane ordered-event sequence checker with per-step cycle windows.
// Optional RM_LANE_TIMESTAMP_EN adds a free-running cycle counter and match_ts_o.
module rm_lane_sequencer
    import rm_lane_sequencer_pkg::*;
#(
    parameter int NUM_EVENTS = 10,
    parameter int DEPTH      = 4,
    parameter int WIN_W      = 16,
    parameter int CNT_W      = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_EVENTS-1:0]           lane_vector_i,
    input  logic                            lane_reset_i,
    input  logic                            cfg_we_i,
    input  logic [rm_idx_w(DEPTH)-1:0]      cfg_addr_i,
    input  logic [rm_idx_w(NUM_EVENTS)-1:0] cfg_event_i,
    input  logic [WIN_W-1:0]                cfg_window_i,
    input  logic [$clog2(DEPTH+1)-1:0]      cfg_len_i,
    output logic                            match_o,
    output logic                            abort_o,
    output logic                            busy_o,
    output logic [rm_idx_w(DEPTH)-1:0]      step_o,
    output logic [CNT_W-1:0]                match_cnt_o
`ifdef RM_LANE_TIMESTAMP_EN
    ,
    output logic [CNT_W-1:0]                match_ts_o
`endif
);

    localparam int EV_W    = rm_idx_w(NUM_EVENTS);
    localparam int STEP_W  = rm_idx_w(DEPTH);
    localparam int LEN_W   = $clog2(DEPTH+1);
    localparam int EV_SPAN = 1 << EV_W;

    typedef struct packed {
        logic [EV_W-1:0]  ev;
        logic [WIN_W-1:0] win;
    } rm_step_t;

    rm_step_t        r_tbl [DEPTH];
    rm_seq_state_e   r_state;
    rm_seq_state_e   w_state_nxt;
    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] w_step_nxt;
    logic [STEP_W-1:0] w_next_idx;
    logic [LEN_W-1:0]  r_len_q;
    logic [LEN_W-1:0]  w_len_eff;
    logic [CNT_W-1:0]  r_match_cnt;
    logic              r_abort;
    logic              w_abort_nxt;
    logic              w_enter_hit;
    logic              w_len_chg;
    logic              w_hit;
    logic              w_last;
    logic              w_tmr_clear;
    logic              w_tmr_load;
    logic [WIN_W-1:0]  w_tmr_val;
    logic              w_tmr_expire;
    logic [EV_SPAN-1:0] w_vec_pad;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tbl[i] <= '0;
            end
        end else if (cfg_we_i && (int'(cfg_addr_i) < DEPTH)) begin
            r_tbl[cfg_addr_i] <= '{ev: cfg_event_i, win: cfg_window_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_len_q <= '0;
        end else begin
            r_len_q <= cfg_len_i;
        end
    end

    // Lengths beyond the table depth are clamped so the step index never runs off the table.
    assign w_len_eff  = (cfg_len_i > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cfg_len_i;
    assign w_len_chg  = (cfg_len_i != r_len_q);
    assign w_next_idx = r_step + 1'b1;
    assign w_last     = ((LEN_W'(r_step) + LEN_W'(1)) == w_len_eff);

    // Zero padding makes event indices at or above NUM_EVENTS read as never-firing.
    assign w_vec_pad  = EV_SPAN'(lane_vector_i);
    assign w_hit      = w_vec_pad[r_tbl[r_step].ev];

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_tmr_clear = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = r_tbl[w_next_idx].win;
        w_abort_nxt = 1'b0;
        w_enter_hit = 1'b0;

        if (lane_reset_i || cfg_we_i || w_len_chg || (w_len_eff == '0)) begin
            w_state_nxt = (w_len_eff == '0) ? ST_DISABLED : ST_SEEK;
            w_step_nxt  = '0;
            w_tmr_clear = 1'b1;
        end else begin
            unique case (r_state)
                ST_DISABLED: begin
                    w_state_nxt = ST_SEEK;
                    w_step_nxt  = '0;
                    w_tmr_clear = 1'b1;
                end
                ST_SEEK, ST_TRACK: begin
                    if (w_hit) begin
                        if (w_last) begin
                            w_state_nxt = ST_HIT;
                            w_step_nxt  = '0;
                            w_tmr_clear = 1'b1;
                            w_enter_hit = 1'b1;
                        end else begin
                            w_state_nxt = ST_TRACK;
                            w_step_nxt  = w_next_idx;
                            w_tmr_load  = 1'b1;
                        end
                    end else if ((r_state == ST_TRACK) && (r_tbl[r_step].win != '0)
                                 && w_tmr_expire) begin
                        w_state_nxt = ST_SEEK;
                        w_step_nxt  = '0;
                        w_tmr_clear = 1'b1;
                        w_abort_nxt = 1'b1;
                    end
                end
                ST_HIT: begin
                    w_state_nxt = ST_SEEK;
                    w_step_nxt  = '0;
                    w_tmr_clear = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_SEEK;
                    w_step_nxt  = '0;
                    w_tmr_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_SEEK;
            r_step  <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_match_cnt <= '0;
        end else if (lane_reset_i) begin
            r_match_cnt <= '0;
        end else if (w_enter_hit && (r_match_cnt != {CNT_W{1'b1}})) begin
            r_match_cnt <= r_match_cnt + 1'b1;
        end
    end

    rm_lane_sequencer_timer #(
        .WIN_W (WIN_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_clear    (w_tmr_clear),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expire   (w_tmr_expire)
    );

`ifdef RM_LANE_TIMESTAMP_EN
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_match_ts;

    // The stamp is taken on the edge entering HIT so it equals the counter while match_o is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cycle    <= '0;
            r_match_ts <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
            if (w_enter_hit) begin
                r_match_ts <= r_cycle + 1'b1;
            end
        end
    end

    assign match_ts_o = r_match_ts;
`endif

    assign match_o     = (r_state == ST_HIT);
    assign abort_o     = r_abort;
    assign busy_o      = (r_state == ST_TRACK);
    assign step_o      = r_step;
    assign match_cnt_o = r_match_cnt;

endmodule

// File: tb/tb_rm_lane_sequencer.sv
// Scoreboard bench for rm_lane_sequencer: stimulus queues expected match/abort pulses, a monitor checks them.
module tb_rm_lane_sequencer;

    localparam int NUM_EVENTS = 10;
    localparam int DEPTH      = 4;
    localparam int WIN_W      = 16;
    localparam int CNT_W      = 2;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b1;
    logic [NUM_EVENTS-1:0] lane_vector_i = '0;
    logic                  lane_reset_i = 1'b0;
    logic                  cfg_we_i = 1'b0;
    logic [1:0]            cfg_addr_i = '0;
    logic [3:0]            cfg_event_i = '0;
    logic [WIN_W-1:0]      cfg_window_i = '0;
    logic [2:0]            cfg_len_i = '0;
    logic                  match_o;
    logic                  abort_o;
    logic                  busy_o;
    logic [1:0]            step_o;
    logic [CNT_W-1:0]      match_cnt_o;
`ifdef RM_LANE_TIMESTAMP_EN
    logic [CNT_W-1:0]      match_ts_o;
`endif

    rm_lane_sequencer #(
        .NUM_EVENTS (NUM_EVENTS),
        .DEPTH      (DEPTH),
        .WIN_W      (WIN_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .lane_vector_i (lane_vector_i),
        .lane_reset_i  (lane_reset_i),
        .cfg_we_i      (cfg_we_i),
        .cfg_addr_i    (cfg_addr_i),
        .cfg_event_i   (cfg_event_i),
        .cfg_window_i  (cfg_window_i),
        .cfg_len_i     (cfg_len_i),
        .match_o       (match_o),
        .abort_o       (abort_o),
        .busy_o        (busy_o),
        .step_o        (step_o),
        .match_cnt_o   (match_cnt_o)
`ifdef RM_LANE_TIMESTAMP_EN
        ,
        .match_ts_o    (match_ts_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    int rel_cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        bit is_match;
        int cyc;
        int cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every match/abort pulse must correspond to the oldest queued expectation.
    always @(negedge clk_i) begin
        if (!rst_i && (match_o || abort_o)) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_pulse: match=%0d abort=%0d at cycle %0d, expected none",
                         match_o, abort_o, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_match", int'(match_o), int'(mon_e.is_match));
                check("pulse_abort", int'(abort_o), int'(!mon_e.is_match));
                check("pulse_cycle", cyc, mon_e.cyc);
                check("pulse_cnt", int'(match_cnt_o), mon_e.cnt);
                check("pulse_step", int'(step_o), 0);
`ifdef RM_LANE_TIMESTAMP_EN
                if (mon_e.is_match) check("match_ts", int'(match_ts_o), (mon_e.cyc - rel_cyc) % (1 << CNT_W));
`endif
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic cfg_step(input int a, input int ev, input int win);
        cfg_addr_i   = 2'(a);
        cfg_event_i  = 4'(ev);
        cfg_window_i = WIN_W'(win);
        cfg_we_i     = 1'b1;
        tick(1);
        cfg_we_i     = 1'b0;
    endtask

    task automatic expect_pulse(input bit is_match, input int rel, input int cnt);
        exp_t e;
        e.is_match = is_match;
        e.cyc      = cyc + rel;
        e.cnt      = cnt;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int b = 0;
        while (sb_q.size() > 0 && b < budget) begin
            tick(1);
            b++;
        end
        check({name, "_drained"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic check_state(input string name, input int busy, input int step, input int cnt);
        check({name, "_busy"}, int'(busy_o), busy);
        check({name, "_step"}, int'(step_o), step);
        check({name, "_cnt"}, int'(match_cnt_o), cnt);
    endtask

    initial begin
        tick(2);
        check("rst_match", int'(match_o), 0);
        check("rst_abort", int'(abort_o), 0);
        check_state("rst", 0, 0, 0);
        rst_i = 1'b0;
        rel_cyc = cyc;

        cfg_step(0, 2, 0);
        cfg_step(1, 5, 0);
        cfg_step(2, 7, 0);
        cfg_len_i = 3'd3;
        tick(2);

        // Sequence 2,5,7 with distractors and a double-bit vector that may advance only one step.
        lane_vector_i = 10'(1 << 2); tick(1);
        check_state("s1_armed", 1, 1, 0);
        lane_vector_i = 10'(1 << 7); tick(1);
        check_state("s1_wrong_ev", 1, 1, 0);
        lane_vector_i = '0; tick(2);
        check_state("s1_unbounded", 1, 1, 0);
        lane_vector_i = 10'((1 << 5) | (1 << 7)); tick(1);
        check_state("s1_one_step", 1, 2, 0);
        lane_vector_i = '0; tick(3);
        lane_vector_i = 10'(1 << 7);
        expect_pulse(1'b1, 1, 1);
        tick(1);
        lane_vector_i = '0;
        drain("s1", 5);
        check_state("s1_done", 0, 0, 1);

        // Window of 4 on step 1 with no ev5: abort four cycles after the arming cycle's response.
        cfg_step(1, 5, 4);
        tick(1);
        lane_vector_i = 10'(1 << 2);
        expect_pulse(1'b0, 5, 1);
        tick(1);
        lane_vector_i = '0;
        drain("s2", 10);
        check_state("s2_done", 0, 0, 1);

        // ev5 on the last allowed cycle (timer==1): the hit wins.
        lane_vector_i = 10'(1 << 2); tick(1);
        lane_vector_i = '0; tick(3);
        lane_vector_i = 10'(1 << 5); tick(1);
        check_state("s2b_edge_hit", 1, 2, 1);
        lane_vector_i = 10'(1 << 7);
        expect_pulse(1'b1, 1, 2);
        tick(1);
        lane_vector_i = '0;
        drain("s2b", 5);

        // Lane reset mid-TRACK clears step and count but keeps the table.
        lane_vector_i = 10'(1 << 2); tick(1);
        lane_vector_i = '0;
        check_state("s3_armed", 1, 1, 2);
        lane_reset_i = 1'b1; tick(1);
        lane_reset_i = 1'b0;
        check_state("s3_reset", 0, 0, 0);
        lane_vector_i = 10'(1 << 2); tick(1);
        lane_vector_i = '0;
        check_state("s3_rearm", 1, 1, 0);

        // Config write while tracking returns to SEEK without an abort pulse.
        cfg_step(1, 5, 4);
        check_state("s3_cfg_abort", 0, 0, 0);
        tick(6);

        // len=1, ev0 held: HIT ignores events so matches alternate; count saturates at 3.
        cfg_step(0, 0, 0);
        cfg_len_i = 3'd1;
        tick(2);
        lane_vector_i = 10'(1 << 0);
        expect_pulse(1'b1, 1, 1);
        expect_pulse(1'b1, 3, 2);
        expect_pulse(1'b1, 5, 3);
        expect_pulse(1'b1, 7, 3);
        expect_pulse(1'b1, 9, 3);
        tick(10);
        lane_vector_i = '0;
        drain("s4", 4);
        check_state("s4_sat", 0, 0, 3);

        // len=0 disables the lane.
        cfg_len_i = 3'd0;
        tick(2);
        lane_vector_i = '1; tick(4);
        lane_vector_i = '0; tick(2);
        check_state("s5_disabled", 0, 0, 3);

        // Event index beyond NUM_EVENTS never matches.
        cfg_step(0, 12, 0);
        cfg_len_i = 3'd1;
        tick(2);
        lane_vector_i = '1; tick(4);
        lane_vector_i = '0; tick(2);
        check_state("s6_oob_event", 0, 0, 3);

        // Highest legal event index does match.
        lane_reset_i = 1'b1; tick(1);
        lane_reset_i = 1'b0;
        check_state("s7_reset", 0, 0, 0);
        cfg_step(0, 9, 0);
        tick(1);
        lane_vector_i = 10'(1 << 9);
        expect_pulse(1'b1, 1, 1);
        tick(1);
        lane_vector_i = '0;
        drain("s7", 5);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
